fft_bin_writer: RTL and testbench
=================================

Name: fft_bin_writer

Overview:
Writer side of the FFT result memory that find_freq scans. Accepts a stream of complex FFT bins over a valid/ready handshake and scales and saturates each value to 10-bit signed. Writes the real part at address bin and the imaginary part at address bin+IMAG_OFFSET through a single write port. When a frame is complete it pulses frame_done, which drives find_freq's enable.

Parameters:
IN_W, 16, width of signed input real/imag samples
DATA_W, 10, width of signed stored values (matches find_freq data_in)
ADDR_W, 11, memory address width
N_BINS, 512, bins per frame (addresses 0..N_BINS-1)
IMAG_OFFSET, 1024, address offset of the imaginary region
SHIFT, 6, arithmetic right shift applied before saturation

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  arms a new frame; ignored unless idle
in_valid  in  1  input bin valid
in_ready  out  1  block can accept a bin
in_re  in  IN_W  signed real part
in_im  in  IN_W  signed imaginary part
in_last  in  1  marks the final bin of the upstream frame
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  signed write data
mem_we  out  1  write enable
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse at end of frame
len_err  out  1  sticky; set on short or long frame; cleared by start

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs low/zero: in_ready, mem_we, mem_addr, mem_wdata, busy, frame_done, len_err. bin counter = 0.
- All outputs are registered.
- States: IDLE, ARMED, WR_RE, WR_IM, FILL_RE, FILL_IM, DRAIN, DONE.
- IDLE: on start go to ARMED. In the same cycle: busy<=1, bin<=0, len_err<=0.
- ARMED: in_ready=1. A beat is accepted on in_valid&in_ready. On acceptance:
  - latch sat(in_re) and sat(in_im) and in_last; in_ready drops next cycle.
  - go to WR_RE.
- WR_RE: mem_we=1, mem_addr=bin, mem_wdata=re_q. Go to WR_IM.
- WR_IM: mem_we=1, mem_addr=bin+IMAG_OFFSET, mem_wdata=im_q. Then:
  - bin==N_BINS-1 and last_q: go to DONE.
  - bin==N_BINS-1 and not last_q: len_err<=1, go to DRAIN.
  - bin<N_BINS-1 and last_q: len_err<=1, bin++, go to FILL_RE.
  - otherwise: bin++, go to ARMED.
- Timing: acceptance at edge T; real write visible cycle T+1; imag write T+2; in_ready high again T+3. Throughput is one bin per 3 cycles.
- FILL_RE/FILL_IM: write 0 to bin and to bin+IMAG_OFFSET, 2 cycles per bin, until bin N_BINS-1 is written; then go to DONE. in_ready=0.
- DRAIN: in_ready=1; accepted beats are discarded with no writes. The beat carrying in_last moves to DONE.
- DONE: frame_done=1 for exactly one cycle, busy<=0, go to IDLE.
- sat(x): y = x >>> SHIFT (arithmetic, floor toward -inf), then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Address arithmetic is ADDR_W wide. bin+IMAG_OFFSET never wraps for the default parameters.
- start while busy: ignored.
- start and a beat in the same cycle in IDLE: the beat is not accepted (in_ready is still 0).
- in_valid while not ready: held by upstream; no side effects.
- Reset mid-frame: immediate IDLE. No frame_done. No further writes; the write in progress in that cycle is dropped because mem_we is registered low.
- mem_we is never high in IDLE, ARMED, DRAIN or DONE.

Decomposition:
- Shared package fft_mem_pkg: N_BINS, IMAG_OFFSET, DATA_W, ADDR_W. find_freq also uses these constants.
- The state enum is local.
- One sub-module, sat_shift: purely combinational, parameters IN_W/DATA_W/SHIFT. Instantiated twice (re, im).

Test Plan:
- Full frame of 512 bins, in_re=bin*64, in_im=-bin*64, in_last on bin 511:
  - mem shows real[k]=k clamped to 511, imag[k]=-k clamped to -512;
  - exactly 1024 writes; single frame_done; len_err=0.
- Saturation, one bin:
  - in_re=16'sh7FFF gives 511; in_re=-32768 gives -512;
  - in_im=1000 gives 15; in_im=-1000 gives -16.
- Short frame, in_last on bin 9:
  - bins 0..9 hold data; bins 10..511 (both regions) are written 0;
  - len_err=1; frame_done after the fill.
- Long frame, 515 beats with in_last on beat 514:
  - 512 bins written; beats 512..514 accepted and discarded;
  - len_err=1; frame_done one cycle after beat 514.
- Handshake: in_valid toggling randomly and start pulsed mid-frame:
  - no beat lost or duplicated; start ignored;
  - in_ready low in cycles T+1 and T+2 after each acceptance.
- rst asserted during WR_IM of bin 100:
  - next cycle mem_we=0, busy=0, state IDLE; frame_done never pulses;
  - a new start then completes a clean frame.

Source files
------------

// File: rtl/fft_mem_pkg.sv
// Geometry of the FFT result memory shared by fft_bin_writer and find_freq.
package fft_mem_pkg;

  localparam int N_BINS      = 512;
  localparam int IMAG_OFFSET = 1024;
  localparam int DATA_W      = 10;
  localparam int ADDR_W      = 11;

  typedef logic signed [DATA_W-1:0] mem_data_t;
  typedef logic [ADDR_W-1:0]        mem_addr_t;

endpackage

// File: rtl/fft_bin_writer_if.sv
// Bin stream, frame control and memory write port of fft_bin_writer.
interface fft_bin_writer_if #(
  parameter int IN_W = 16
) ();

  // in_valid/in_ready: a beat transfers on a rising clk edge where both are
  // high; while in_valid is high and in_ready low, upstream holds in_re,
  // in_im and in_last stable. in_ready never depends combinationally on
  // in_valid.
  logic                              start;
  logic                              in_valid;
  logic                              in_ready;
  logic signed [IN_W-1:0]            in_re;
  logic signed [IN_W-1:0]            in_im;
  logic                              in_last;
  logic [fft_mem_pkg::ADDR_W-1:0]    mem_addr;
  logic signed [fft_mem_pkg::DATA_W-1:0] mem_wdata;
  logic                              mem_we;
  logic                              busy;
  logic                              frame_done;
  logic                              len_err;

  modport master (
    output start, in_valid, in_re, in_im, in_last,
    input  in_ready, mem_addr, mem_wdata, mem_we, busy, frame_done, len_err
  );

  modport slave (
    input  start, in_valid, in_re, in_im, in_last,
    output in_ready, mem_addr, mem_wdata, mem_we, busy, frame_done, len_err
  );

endinterface

// File: rtl/fft_bin_writer_sat_shift.sv
// Arithmetic right shift (floor) followed by clamp to a narrower signed range.
module sat_shift #(
  parameter int IN_W   = 16,
  parameter int DATA_W = 10,
  parameter int SHIFT  = 6
) (
  input  logic signed [IN_W-1:0]   x,
  output logic signed [DATA_W-1:0] y
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (DATA_W - 1)));

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = x >>> SHIFT;
    if (shifted > MAX_V) begin
      y = MAX_V[DATA_W-1:0];
    end else if (shifted < MIN_V) begin
      y = MIN_V[DATA_W-1:0];
    end else begin
      y = shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/fft_bin_writer.sv
// Writes a frame of saturated complex FFT bins into the find_freq memory:
// real part at bin, imaginary part at bin+IMAG_OFFSET, then pulses frame_done.
module fft_bin_writer
  import fft_mem_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int SHIFT = 6
) (
  input  logic            clk,
  input  logic            rst,
  fft_bin_writer_if.slave bus,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_WR_RE   = 3'd2,
    S_WR_IM   = 3'd3,
    S_FILL_RE = 3'd4,
    S_FILL_IM = 3'd5,
    S_DRAIN   = 3'd6,
    S_DONE    = 3'd7
  } state_e;

  localparam mem_addr_t LAST_BIN  = ADDR_W'(N_BINS - 1);
  localparam mem_addr_t IMAG_BASE = ADDR_W'(IMAG_OFFSET);

  state_e    state_q, state_d;
  mem_addr_t bin_q, bin_d;
  mem_data_t re_q, re_d;
  mem_data_t im_q, im_d;
  logic      last_q, last_d;
  logic      in_ready_q, in_ready_d;
  logic      mem_we_q, mem_we_d;
  mem_addr_t mem_addr_q, mem_addr_d;
  mem_data_t mem_wdata_q, mem_wdata_d;
  logic      busy_q, busy_d;
  logic      frame_done_q, frame_done_d;
  logic      len_err_q, len_err_d;

  mem_data_t re_sat;
  mem_data_t im_sat;
  logic      accept;

  sat_shift #(.IN_W(IN_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_sat_re (
    .x (bus.in_re),
    .y (re_sat)
  );

  sat_shift #(.IN_W(IN_W), .DATA_W(DATA_W), .SHIFT(SHIFT)) u_sat_im (
    .x (bus.in_im),
    .y (im_sat)
  );

  assign accept = bus.in_valid && in_ready_q;

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    re_d      = re_q;
    im_d      = im_q;
    last_d    = last_q;
    len_err_d = len_err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_ARMED;
          bin_d     = '0;
          len_err_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (accept) begin
          re_d    = re_sat;
          im_d    = im_sat;
          last_d  = bus.in_last;
          state_d = S_WR_RE;
        end
      end
      S_WR_RE: state_d = S_WR_IM;
      S_WR_IM: begin
        if (bin_q == LAST_BIN) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            len_err_d = 1'b1;
            state_d   = S_DRAIN;
          end
        end else begin
          bin_d = bin_q + ADDR_W'(1);
          if (last_q) begin
            // Upstream ended early: zero the rest of the frame so find_freq
            // never scans stale bins from a previous frame.
            len_err_d = 1'b1;
            state_d   = S_FILL_RE;
          end else begin
            state_d = S_ARMED;
          end
        end
      end
      S_FILL_RE: state_d = S_FILL_IM;
      S_FILL_IM: begin
        if (bin_q == LAST_BIN) begin
          state_d = S_DONE;
        end else begin
          bin_d   = bin_q + ADDR_W'(1);
          state_d = S_FILL_RE;
        end
      end
      S_DRAIN: begin
        if (accept && bus.in_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    in_ready_d   = (state_d == S_ARMED) || (state_d == S_DRAIN);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    frame_done_d = (state_d == S_DONE);
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    case (state_d)
      S_WR_RE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = bin_d;
        mem_wdata_d = re_d;
      end
      S_WR_IM: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = bin_d + IMAG_BASE;
        mem_wdata_d = im_d;
      end
      S_FILL_RE: begin
        mem_we_d   = 1'b1;
        mem_addr_d = bin_d;
      end
      S_FILL_IM: begin
        mem_we_d   = 1'b1;
        mem_addr_d = bin_d + IMAG_BASE;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      re_q         <= '0;
      im_q         <= '0;
      last_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      re_q         <= re_d;
      im_q         <= im_d;
      last_q       <= last_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.len_err    = len_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_fft_bin_writer.sv
// Bench for fft_bin_writer: drives frames of bins and scoreboards every memory write.
module tb_fft_bin_writer;
  import fft_mem_pkg::*;

  localparam int MAX_WR   = 16384;
  localparam int SAT_DIV  = 64;
  localparam int SAT_LIM  = 512;
  localparam int ST_IDLE  = 0;
  localparam int ST_ARMED = 1;
  localparam int ST_WR_IM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  fft_bin_writer_if bus_if ();

  fft_bin_writer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_q[$];
  int          rd_idx = 0;
  int          fr_fd0 = 0;
  int          fr_wr0 = 0;

  logic [31:0]              obs_w   [MAX_WR];
  logic signed [DATA_W-1:0] mem_img [2**ADDR_W];
  int n_writes = 0;
  int n_fd     = 0;
  int we_bad   = 0;
  int gap_bad  = 0;
  int gap_n    = 0;
  int rdy_gap  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic int model_sat(input int x);
    int y;
    if (x >= 0) y = x / SAT_DIV;
    else        y = -((-x + SAT_DIV - 1) / SAT_DIV);
    if (y > SAT_LIM - 1) y = SAT_LIM - 1;
    if (y < -SAT_LIM)    y = -SAT_LIM;
    return y;
  endfunction

  function automatic logic [31:0] pack(input int addr, input int data);
    return 32'((addr << DATA_W) | (data & ((1 << DATA_W) - 1)));
  endfunction

  // Write monitor: records every write and frame_done pulse.
  always @(negedge clk) begin
    if (bus_if.mem_we) begin
      if (n_writes < MAX_WR) obs_w[n_writes] <= 32'({bus_if.mem_addr, bus_if.mem_wdata});
      mem_img[bus_if.mem_addr] <= bus_if.mem_wdata;
      n_writes <= n_writes + 1;
      if (!(dbg_state inside {3'd2, 3'd3, 3'd4, 3'd5})) we_bad <= we_bad + 1;
    end
    if (bus_if.frame_done) n_fd <= n_fd + 1;
  end

  // After each acceptance in ARMED, in_ready must stay low for two cycles.
  always @(posedge clk) begin
    if (rdy_gap > 0) begin
      if (bus_if.in_ready) gap_bad <= gap_bad + 1;
      rdy_gap <= rdy_gap - 1;
    end else if (bus_if.in_valid && bus_if.in_ready && dbg_state == 3'(ST_ARMED)) begin
      rdy_gap <= 2;
      gap_n   <= gap_n + 1;
    end
  end

  task automatic drain_writes();
    while (exp_q.size() > 0 && rd_idx < n_writes) begin
      check("wr_addr_data", obs_w[rd_idx], exp_q.pop_front());
      rd_idx++;
    end
    check("wr_missing", 32'(exp_q.size()), 0);
    check("wr_extra", 32'(n_writes - rd_idx), 0);
    exp_q.delete();
    rd_idx = n_writes;
  endtask

  task automatic frame_checks(input int len_err_exp);
    check("frame_done_cnt", 32'(n_fd - fr_fd0), 1);
    check("write_cnt", 32'(n_writes - fr_wr0), 2 * N_BINS);
    check("len_err", 32'(bus_if.len_err), 32'(len_err_exp));
    check("busy_end", 32'(bus_if.busy), 0);
    check("state_end", 32'(dbg_state), ST_IDLE);
    check("in_ready_end", 32'(bus_if.in_ready), 0);
    check("rdy_gap", 32'(gap_bad), 0);
    check("we_state", 32'(we_bad), 0);
    drain_writes();
  endtask

  // mode 0: ramp re=b*64 im=-b*64; mode 1: saturation table; mode 2: random.
  task automatic run_frame(input int n_beats, input int mode, input bit rnd,
                           input int abort_bin, output bit fd_at_acc);
    int re, im, wt;
    bit last;
    fd_at_acc = 1'b0;
    fr_fd0 = n_fd;
    fr_wr0 = n_writes;
    // A beat presented together with start must not be taken in IDLE.
    bus_if.start    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_re    = 16'sd7;
    bus_if.in_im    = 16'sd7;
    @(negedge clk);
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b0;
    check("busy_after_start", 32'(bus_if.busy), 1);
    check("len_err_cleared", 32'(bus_if.len_err), 0);
    for (int b = 0; b < n_beats; b++) begin
      case (mode)
        0: begin re = b * 64; im = -b * 64; end
        1: begin
          if (b == 0) begin re = 32767;  im = 1000;  end
          else        begin re = -32768; im = -1000; end
        end
        default: begin
          re = int'($urandom_range(0, 65535)) - 32768;
          im = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      last = (b == n_beats - 1);
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.in_re    = 16'(re);
      bus_if.in_im    = 16'(im);
      bus_if.in_last  = last;
      if (rnd && $urandom_range(0, 7) == 0) bus_if.start = 1'b1;
      wt = 0;
      while (!bus_if.in_ready && wt < 20) begin
        @(negedge clk);
        bus_if.start = 1'b0;
        if (rnd && $urandom_range(0, 3) == 0) bus_if.start = 1'b1;
        wt++;
      end
      if (!bus_if.in_ready) begin
        check("ready_timeout", 32'(bus_if.in_ready), 1);
        bus_if.in_valid = 1'b0;
        bus_if.start    = 1'b0;
        return;
      end
      if (b < N_BINS) begin
        exp_q.push_back(pack(b, model_sat(re)));
        exp_q.push_back(pack(b + IMAG_OFFSET, model_sat(im)));
      end
      if (last && b < N_BINS - 1) begin
        for (int k = b + 1; k < N_BINS; k++) begin
          exp_q.push_back(pack(k, 0));
          exp_q.push_back(pack(k + IMAG_OFFSET, 0));
        end
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      bus_if.start    = 1'b0;
      fd_at_acc = bus_if.frame_done;
      if (b == abort_bin) begin
        @(negedge clk);
        check("abort_in_wr_im", 32'(dbg_state), ST_WR_IM);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mem_we", 32'(bus_if.mem_we), 0);
        check("rst_busy", 32'(bus_if.busy), 0);
        check("rst_state", 32'(dbg_state), ST_IDLE);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rst_no_frame_done", 32'(n_fd - fr_fd0), 0);
        check("rst_write_cnt", 32'(n_writes - fr_wr0), 2 * (abort_bin + 1));
        drain_writes();
        return;
      end
    end
    wt = 0;
    while (n_fd == fr_fd0 && wt < 4000) begin
      @(negedge clk);
      wt++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fd_acc;
    bus_if.start    = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_re    = '0;
    bus_if.in_im    = '0;
    bus_if.in_last  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus_if.in_ready), 0);
    check("rst_mem_we0", 32'(bus_if.mem_we), 0);
    check("rst_mem_addr", 32'(bus_if.mem_addr), 0);
    check("rst_mem_wdata", 32'(bus_if.mem_wdata), 0);
    check("rst_busy0", 32'(bus_if.busy), 0);
    check("rst_frame_done", 32'(bus_if.frame_done), 0);
    check("rst_len_err", 32'(bus_if.len_err), 0);
    check("rst_state0", 32'(dbg_state), ST_IDLE);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_no_start", 32'(dbg_state), ST_IDLE);

    // Full ramp frame
    run_frame(512, 0, 1'b0, -1, fd_acc);
    frame_checks(0);
    check("full_re_300", 32'(mem_img[300]), 300);
    check("full_im_300", 32'(mem_img[IMAG_OFFSET + 300]), -300);
    check("full_re_511", 32'(mem_img[511]), 511);
    check("full_im_511", 32'(mem_img[IMAG_OFFSET + 511]), -511);

    // Saturation: two bins then zero fill
    run_frame(2, 1, 1'b0, -1, fd_acc);
    frame_checks(1);
    check("sat_re_pos", 32'(mem_img[0]), 511);
    check("sat_re_neg", 32'(mem_img[1]), -512);
    check("sat_im_pos", 32'(mem_img[IMAG_OFFSET]), 15);
    check("sat_im_neg", 32'(mem_img[IMAG_OFFSET + 1]), -16);
    check("sat_fill_re2", 32'(mem_img[2]), 0);

    // Short frame, in_last on bin 9
    run_frame(10, 0, 1'b0, -1, fd_acc);
    frame_checks(1);
    check("short_re_9", 32'(mem_img[9]), 9);
    check("short_im_9", 32'(mem_img[IMAG_OFFSET + 9]), -9);
    check("short_re_10", 32'(mem_img[10]), 0);
    check("short_im_511", 32'(mem_img[IMAG_OFFSET + 511]), 0);

    // Long frame, 515 beats
    run_frame(515, 0, 1'b0, -1, fd_acc);
    frame_checks(1);
    check("long_fd_after_last", 32'(fd_acc), 1);
    check("long_re_511", 32'(mem_img[511]), 511);

    // Random valid gaps and stray start pulses
    run_frame(512, 2, 1'b1, -1, fd_acc);
    frame_checks(0);
    check("rdy_gap_exercised", 32'(gap_n > 1000), 1);

    // Reset during WR_IM of bin 100, then a clean frame
    run_frame(512, 0, 1'b0, 100, fd_acc);
    run_frame(512, 0, 1'b0, -1, fd_acc);
    frame_checks(0);
    check("post_rst_re_200", 32'(mem_img[200]), 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
